// File: rtl/button_pulser.sv
// button_pulser: per-button synchronizer, debounce filter, press pulse and hold-to-auto-repeat
module button_pulser #(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] level,
  output logic [NUM_BTN-1:0] pulse
);
  localparam int DW   = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = RMAX > 1 ? $clog2(RMAX) : 1;
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);
  localparam logic          REP_OFF  = REPEAT_DELAY == 0;
  typedef enum logic {FIRST, REPEAT} phase_t;
  for (genvar i = 0; i < NUM_BTN; i++) begin : ch
    logic s1, s2, lvl_q, pls_q, lvl_nxt, rise, clr, rep_hit, pls_nxt;
    logic [DW-1:0] db_cnt, db_nxt;
    logic [RW-1:0] rep_cnt, rep_nxt, rep_last;
    phase_t phase, phase_nxt;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1      <= 1'b0;
        s2      <= 1'b0;
        db_cnt  <= '0;
        lvl_q   <= 1'b0;
        pls_q   <= 1'b0;
        rep_cnt <= '0;
        phase   <= FIRST;
      end else begin
        s1      <= btn_raw[i];
        s2      <= s1;
        db_cnt  <= db_nxt;
        lvl_q   <= lvl_nxt;
        pls_q   <= pls_nxt;
        rep_cnt <= rep_nxt;
        phase   <= phase_nxt;
      end
    end
    // a release or a disabled enable parks the repeat timer so the next arm starts fresh
    always_comb begin
      db_nxt    = (s2 == lvl_q || db_cnt == DB_LAST) ? '0 : db_cnt + DW'(1);
      lvl_nxt   = (s2 != lvl_q && db_cnt == DB_LAST) ? s2 : lvl_q;
      rise      = lvl_nxt & ~lvl_q;
      clr       = ~lvl_q | ~en | REP_OFF;
      rep_last  = phase == FIRST ? DLY_LAST : PER_LAST;
      rep_hit   = ~clr && rep_cnt == rep_last;
      rep_nxt   = (clr || rep_hit) ? '0 : rep_cnt + RW'(1);
      phase_nxt = clr ? FIRST : rep_hit ? REPEAT : phase;
      pls_nxt   = (en & rise) | rep_hit;
    end
    assign level[i] = lvl_q;
    assign pulse[i] = pls_q;
  end
endmodule

// File: tb/tb_button_pulser.sv
// tb_button_pulser: randomized and directed stimulus scored against a time-window reference model
module tb_button_pulser;
  localparam int NB = 2, D = 4, RD = 10, RP = 3;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [1:0] btn_raw = 2'b00, level, pulse;
  int total = 0, bad = 0;
  logic [3:0] expq[$];
  bit smp[2][0:8191];
  int n = 0, base = 0;
  int last_flip[2], t0[2];
  bit lvl[2], cprev[2];

  button_pulser #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst(rst), .en(en), .btn_raw(btn_raw), .level(level), .pulse(pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b at %0t", name, act, want, $time);
    end
  endtask

  function automatic bit s2v(input int c, input int k);
    return (k < base) ? 1'b0 : smp[c][k];
  endfunction

  task automatic model_reset();
    base = n;
    for (int c = 0; c < 2; c++) begin
      last_flip[c] = n - 1;
      lvl[c] = 1'b0;
      cprev[c] = 1'b0;
      t0[c] = 0;
    end
  endtask

  // level flips once the last D synchronized samples (all after the previous flip) disagree with it;
  // repeats fire at t0+RD-1+k*RP where t0 is the first edge of an unbroken held-and-enabled stretch
  task automatic model_edge(input logic [1:0] r, input logic e);
    logic [1:0] l_o, p_o;
    bit old, flip, cond;
    for (int c = 0; c < 2; c++) begin
      smp[c][n] = r[c];
      old = lvl[c];
      flip = 1'b1;
      for (int j = n - D + 1; j <= n; j++)
        if (j <= last_flip[c] || s2v(c, j - 2) == old) flip = 1'b0;
      if (flip) begin
        lvl[c] = ~old;
        last_flip[c] = n;
      end
      cond = old & e;
      if (cond && !cprev[c]) t0[c] = n;
      cprev[c] = cond;
      p_o[c] = (lvl[c] & ~old & e) |
               (cond && (n - t0[c]) >= RD - 1 && ((n - t0[c] - (RD - 1)) % RP) == 0);
      l_o[c] = lvl[c];
    end
    expq.push_back({l_o, p_o});
    n++;
  endtask

  task automatic step(input logic [1:0] r, input logic e, input bit do_rst);
    @(negedge clk);
    btn_raw = r;
    en = e;
    if (do_rst) begin
      #2 rst = 1'b1;
      #1 chk("async_rst_level", level, 2'b00);
      chk("async_rst_pulse", pulse, 2'b00);
      #1 rst = 1'b0;
      model_reset();
    end
    model_edge(r, e);
  endtask

  task automatic hold(input logic [1:0] r, input logic e, input int cnt);
    repeat (cnt) step(r, e, 1'b0);
  endtask

  initial begin
    logic [3:0] x;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        x = expq.pop_front();
        chk("level", level, x[3:2]);
        chk("pulse", pulse, x[1:0]);
      end
    end
  end

  initial begin
    logic [1:0] cur;
    int cnt[2];
    int ecnt;
    logic ecur;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_level", level, 2'b00);
    chk("reset_pulse", pulse, 2'b00);
    rst = 1'b0;
    en = 1'b1;
    model_edge(2'b00, 1'b1);
    hold(2'b01, 1, 8);
    hold(2'b00, 1, 10);
    for (int k = 0; k < 6; k++) hold((k % 2) ? 2'b00 : 2'b01, 1, 2);
    hold(2'b01, 1, 8);
    hold(2'b00, 1, 8);
    hold(2'b10, 1, 27);
    hold(2'b00, 1, 10);
    hold(2'b11, 1, 20);
    hold(2'b00, 1, 10);
    hold(2'b01, 0, 7);
    hold(2'b01, 1, 15);
    hold(2'b00, 1, 10);
    hold(2'b01, 1, 4);
    step(2'b01, 1, 1'b1);
    hold(2'b01, 1, 10);
    hold(2'b00, 1, 10);
    hold(2'b11, 1, 12);
    step(2'b11, 1, 1'b1);
    hold(2'b11, 1, 8);
    hold(2'b00, 1, 8);
    cur = 2'b00;
    cnt[0] = 0;
    cnt[1] = 0;
    ecur = 1'b1;
    ecnt = 0;
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < 2; c++) begin
        if (cnt[c] == 0) begin
          cur[c] = $urandom_range(0, 1);
          cnt[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 12);
        end
        cnt[c]--;
      end
      if (ecnt == 0) begin
        ecur = $urandom_range(0, 5) != 0;
        ecnt = $urandom_range(1, 30);
      end
      ecnt--;
      step(cur, ecur, $urandom_range(0, 299) == 0);
    end
    hold(2'b00, 1, 2);
    repeat (3) @(negedge clk);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
